piradip_axis_iq_aligner: RTL and testbench

//  Upstream companion of the I/Q sample interleaver. Takes two independent axi4s

---
 rtl/piradip_axis_iq_aligner_pkg.sv | 24 ++
 rtl/piradip_axis_iq_aligner_if.sv | 20 ++
 rtl/piradip_axis_iq_aligner_fifo.sv | 96 +++++++++
 rtl/piradip_axis_iq_aligner.sv | 127 ++++++++++++
 tb/tb_piradip_axis_iq_aligner.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piradip_axis_iq_aligner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piradip_axis_iq_aligner_pkg
//  Brief    : Shared sample width and occupancy/skew width helpers for the
//             I/Q aligner and its companion interleaver.
//  Revision : 1.0  initial release
// ============================================================================
package piradip_axis_iq_aligner_pkg;

    // Width of one real or imaginary sample on the I/Q streams.
    localparam int SAMPLE_WIDTH = 16;

    // Bits needed to hold a FIFO occupancy in the range [0, depth].
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bits needed to hold a signed occupancy difference in [-depth, depth].
    function automatic int skew_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piradip_axis_iq_aligner_if.sv
`default_nettype none
// ============================================================================
//  Module   : piradip_axis_iq_aligner_if
//  Brief    : Minimal AXI4-Stream bundle (tdata/tvalid/tready plus tlast and
//             tkeep sideband) with manager and subordinate views.
//  Revision : 1.0  initial release
// ============================================================================
interface piradip_axis_iq_aligner_if #(
    parameter int W = 16
) ();
    logic [W-1:0]         tdata;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;
    logic [(W+7)/8-1:0]   tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface
`default_nettype wire

// File: rtl/piradip_axis_iq_aligner_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : piradip_axis_iq_aligner_fifo
//  Brief    : Small synchronous FIFO with a registered head word, registered
//             full/empty flags and a next-state occupancy output used by the
//             aligner for skew tracking.
//  Revision : 1.0  initial release
// ============================================================================
module piradip_axis_iq_aligner_fifo
    import piradip_axis_iq_aligner_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SAMPLE_WIDTH
) (
    input  wire logic                        clk,
    input  wire logic                        resetn,
    input  wire logic                        i_valid,
    input  wire logic [W-1:0]                i_data,
    output logic                             o_ready,
    input  wire logic                        i_pop,
    output logic                             o_empty,
    output logic [W-1:0]                     o_head,
    output logic [occ_width(DEPTH)-1:0]      o_occ_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic          r_full;
    logic          r_empty;
    logic          r_active;
    logic [W-1:0]  r_head;

    logic          w_push;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;
    logic [PW-1:0] w_occ_next;
    logic          w_full_next;
    logic          w_empty_next;
    logic [W-1:0]  w_head_next;

    // tready is held low until the first clock after reset release.
    assign o_ready    = r_active & ~r_full;
    assign w_push     = i_valid & o_ready;
    assign w_wr_next  = r_wr + {{AW{1'b0}}, w_push};
    assign w_rd_next  = r_rd + {{AW{1'b0}}, i_pop};
    assign w_occ_next = w_wr_next - w_rd_next;

    // Pointers carry one extra wrap bit: full when only the wrap bits differ.
    assign w_full_next  = (w_wr_next[AW] != w_rd_next[AW]) &&
                          (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    assign w_empty_next = (w_wr_next == w_rd_next);

    assign o_empty    = r_empty;
    assign o_head     = r_head;
    assign o_occ_next = w_occ_next;

    // Next head word: the incoming beat when it lands in the slot about to
    // become the head, otherwise the stored word at the next read pointer.
    always_comb begin
        w_head_next = r_mem[w_rd_next[AW-1:0]];
        if (w_push && (r_wr == w_rd_next)) begin
            w_head_next = i_data;
        end
    end

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    // Pointers, flags and head register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_active <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr     <= w_wr_next;
            r_rd     <= w_rd_next;
            r_full   <= w_full_next;
            r_empty  <= w_empty_next;
            r_active <= 1'b1;
            r_head   <= w_head_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piradip_axis_iq_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : piradip_axis_iq_aligner
//  Brief    : Buffers independently skewed I and Q AXI-stream beats and
//             presents them as beat-aligned pairs with a joint valid and a
//             shared pop. Tracks occupancy skew and flags excessive skew.
//  Revision : 1.0  initial release
// ============================================================================
module piradip_axis_iq_aligner
    import piradip_axis_iq_aligner_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SKEW_LIMIT = 3,
    parameter int W          = SAMPLE_WIDTH
) (
    input  wire logic                          clk,
    input  wire logic                          resetn,
    piradip_axis_iq_aligner_if.slave           I_in,
    piradip_axis_iq_aligner_if.slave           Q_in,
    piradip_axis_iq_aligner_if.master          I_out,
    piradip_axis_iq_aligner_if.master          Q_out,
    output logic signed [skew_width(DEPTH)-1:0] skew,
    output logic                               skew_err
);
    localparam int OW = occ_width(DEPTH);
    localparam int SW = skew_width(DEPTH);

    // Elaboration-time sanity checks on widths and parameters.
    if (($bits(I_in.tdata) != W) || ($bits(Q_in.tdata) != W) ||
        ($bits(I_out.tdata) != W) || ($bits(Q_out.tdata) != W)) begin : g_chk_width
        $error("piradip_axis_iq_aligner: all stream widths must equal W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("piradip_axis_iq_aligner: DEPTH must be a power of 2 and >= 2");
    end
    if (SKEW_LIMIT >= DEPTH) begin : g_chk_skew
        $error("piradip_axis_iq_aligner: SKEW_LIMIT must be below DEPTH");
    end

    logic                 w_ready_i;
    logic                 w_ready_q;
    logic                 w_empty_i;
    logic                 w_empty_q;
    logic [W-1:0]         w_head_i;
    logic [W-1:0]         w_head_q;
    logic [OW-1:0]        w_occ_i;
    logic [OW-1:0]        w_occ_q;
    logic                 w_pair_valid;
    logic                 w_pop;
    logic signed [SW-1:0] w_skew_next;
    logic [SW-1:0]        w_skew_abs;
    logic                 w_skew_over;
    logic                 w_unused_sideband;

    logic signed [SW-1:0] r_skew;
    logic                 r_skew_err;

    // A pair is offered only when both heads exist; both pop together.
    assign w_pair_valid = ~w_empty_i & ~w_empty_q;
    assign w_pop        = w_pair_valid & I_out.tready & Q_out.tready;

    piradip_axis_iq_aligner_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo_i (
        .clk        (clk),
        .resetn     (resetn),
        .i_valid    (I_in.tvalid),
        .i_data     (I_in.tdata),
        .o_ready    (w_ready_i),
        .i_pop      (w_pop),
        .o_empty    (w_empty_i),
        .o_head     (w_head_i),
        .o_occ_next (w_occ_i)
    );

    piradip_axis_iq_aligner_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo_q (
        .clk        (clk),
        .resetn     (resetn),
        .i_valid    (Q_in.tvalid),
        .i_data     (Q_in.tdata),
        .o_ready    (w_ready_q),
        .i_pop      (w_pop),
        .o_empty    (w_empty_q),
        .o_head     (w_head_q),
        .o_occ_next (w_occ_q)
    );

    assign I_in.tready  = w_ready_i;
    assign Q_in.tready  = w_ready_q;

    assign I_out.tvalid = w_pair_valid;
    assign Q_out.tvalid = w_pair_valid;
    assign I_out.tdata  = w_head_i;
    assign Q_out.tdata  = w_head_q;
    assign I_out.tlast  = 1'b0;
    assign Q_out.tlast  = 1'b0;
    assign I_out.tkeep  = '0;
    assign Q_out.tkeep  = '0;

    // Input sideband is intentionally dropped.
    assign w_unused_sideband = I_in.tlast ^ Q_in.tlast ^ (^I_in.tkeep) ^ (^Q_in.tkeep);

    // Signed skew from next-state occupancies, and its magnitude.
    assign w_skew_next = $signed({1'b0, w_occ_i}) - $signed({1'b0, w_occ_q});
    assign w_skew_abs  = w_skew_next[SW-1] ? $unsigned(-w_skew_next) : $unsigned(w_skew_next);
    assign w_skew_over = (w_skew_abs > SW'(SKEW_LIMIT));

    // Registered skew and sticky skew error (cleared only by reset).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_skew     <= '0;
            r_skew_err <= 1'b0;
        end else begin
            r_skew     <= w_skew_next;
            r_skew_err <= r_skew_err | w_skew_over;
        end
    end

    assign skew     = r_skew;
    assign skew_err = r_skew_err;

endmodule
`default_nettype wire

// File: tb/tb_piradip_axis_iq_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piradip_axis_iq_aligner
//  Brief    : Self-checking bench for the I/Q aligner: queue-based reference
//             model, per-cycle compare process, directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piradip_axis_iq_aligner;
    import piradip_axis_iq_aligner_pkg::*;

    localparam int DEPTH      = 4;
    localparam int SKEW_LIMIT = 3;
    localparam int W          = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic signed [skew_width(DEPTH)-1:0] skew;
    logic skew_err;

    always #5 clk = ~clk;

    piradip_axis_iq_aligner_if #(.W(W)) if_i_in  ();
    piradip_axis_iq_aligner_if #(.W(W)) if_q_in  ();
    piradip_axis_iq_aligner_if #(.W(W)) if_i_out ();
    piradip_axis_iq_aligner_if #(.W(W)) if_q_out ();

    piradip_axis_iq_aligner #(
        .DEPTH      (DEPTH),
        .SKEW_LIMIT (SKEW_LIMIT),
        .W          (W)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .I_in     (if_i_in),
        .Q_in     (if_q_in),
        .I_out    (if_i_out),
        .Q_out    (if_q_out),
        .skew     (skew),
        .skew_err (skew_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int d_pairs  = 0;
    int m_pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] mq_i[$];
    logic [W-1:0] mq_q[$];
    bit           m_active = 1'b0;
    int           m_skew   = 0;
    bit           m_err    = 1'b0;

    // Beat-level model: FIFO queues, joint pop, skew from post-edge sizes.
    always @(posedge clk or negedge resetn) begin
        bit rdy_i, rdy_q, pop;
        int d;
        if (!resetn) begin
            mq_i.delete();
            mq_q.delete();
            m_active = 1'b0;
            m_skew   = 0;
            m_err    = 1'b0;
        end else begin
            rdy_i = m_active && (mq_i.size() < DEPTH);
            rdy_q = m_active && (mq_q.size() < DEPTH);
            pop   = (mq_i.size() > 0) && (mq_q.size() > 0) && if_i_out.tready && if_q_out.tready;
            if (pop) begin
                void'(mq_i.pop_front());
                void'(mq_q.pop_front());
                m_pops++;
            end
            if (if_i_in.tvalid && rdy_i) mq_i.push_back(if_i_in.tdata);
            if (if_q_in.tvalid && rdy_q) mq_q.push_back(if_q_in.tdata);
            d = mq_i.size() - mq_q.size();
            m_skew = d;
            if ((d > SKEW_LIMIT) || (-d > SKEW_LIMIT)) m_err = 1'b1;
            m_active = 1'b1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        bit exp_vld;
        exp_vld = (mq_i.size() > 0) && (mq_q.size() > 0);
        chk("I_in.tready", if_i_in.tready, m_active && (mq_i.size() < DEPTH));
        chk("Q_in.tready", if_q_in.tready, m_active && (mq_q.size() < DEPTH));
        chk("I_out.tvalid", if_i_out.tvalid, exp_vld);
        chk("Q_out.tvalid", if_q_out.tvalid, exp_vld);
        if (exp_vld) begin
            chk("I_out.tdata", if_i_out.tdata, mq_i[0]);
            chk("Q_out.tdata", if_q_out.tdata, mq_q[0]);
        end
        chk("skew", skew, m_skew);
        chk("skew_err", skew_err, m_err);
        chk("sideband", {if_i_out.tlast, if_q_out.tlast, if_i_out.tkeep, if_q_out.tkeep}, 0);
        if (if_i_out.tvalid && if_q_out.tvalid && if_i_out.tready && if_q_out.tready) d_pairs++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit vi, input logic [W-1:0] di, input bit vq,
                         input logic [W-1:0] dq, input bit ri, input bit rq);
        if_i_in.tvalid  = vi;
        if_i_in.tdata   = di;
        if_q_in.tvalid  = vq;
        if_q_in.tdata   = dq;
        if_i_out.tready = ri;
        if_q_out.tready = rq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Reset for two cycles, release, then one more edge so inputs are ready.
    task automatic do_reset();
        drive(0, '0, 0, '0, 0, 0);
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int p0;
        if_i_in.tlast  = 1'b0;
        if_q_in.tlast  = 1'b0;
        if_i_in.tkeep  = '1;
        if_q_in.tkeep  = '1;
        drive(0, '0, 0, '0, 0, 0);
        tick();
        tick();
        resetn = 1'b1;

        // ---- 1: reset behaviour and mid-stream reset ----
        at_neg();
        chk("t1 tready before first edge", if_i_in.tready, 1'b0);
        tick();
        at_neg();
        chk("t1 tready after first edge", if_i_in.tready, 1'b1);
        drive(1, 16'hA001, 1, 16'hB001, 0, 0);
        tick();
        drive(1, 16'hA002, 1, 16'hB002, 0, 0);
        tick();
        drive(0, '0, 0, '0, 0, 0);
        at_neg();
        chk("t1 buffered pair valid", if_i_out.tvalid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t1 rst I_out.tvalid", if_i_out.tvalid, 1'b0);
        chk("t1 rst Q_out.tvalid", if_q_out.tvalid, 1'b0);
        chk("t1 rst skew", skew, 0);
        chk("t1 rst skew_err", skew_err, 1'b0);
        chk("t1 rst I_in.tready", if_i_in.tready, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        drive(1, 16'h5555, 1, 16'h6666, 1, 1);
        tick();
        drive(0, '0, 0, '0, 1, 1);
        at_neg();
        chk("t1 first pair I", if_i_out.tdata, 16'h5555);
        chk("t1 first pair Q", if_q_out.tdata, 16'h6666);
        tick();

        // ---- 2: skewed arrival ----
        do_reset();
        drive(1, 16'h1111, 0, '0, 1, 1); tick();
        drive(1, 16'h2222, 0, '0, 1, 1); tick();
        drive(0, '0, 0, '0, 1, 1);
        at_neg();
        chk("t2 skew peak", skew, 2);
        chk("t2 no pair yet", if_i_out.tvalid, 1'b0);
        tick();
        drive(0, '0, 1, 16'hAAAA, 1, 1);
        at_neg();
        chk("t2 skew c3", skew, 2);
        tick();
        drive(0, '0, 1, 16'hBBBB, 1, 1);
        at_neg();
        chk("t2 pair0 valid", if_q_out.tvalid, 1'b1);
        chk("t2 pair0 I", if_i_out.tdata, 16'h1111);
        chk("t2 pair0 Q", if_q_out.tdata, 16'hAAAA);
        chk("t2 skew c4", skew, 1);
        tick();
        drive(0, '0, 0, '0, 1, 1);
        at_neg();
        chk("t2 pair1 I", if_i_out.tdata, 16'h2222);
        chk("t2 pair1 Q", if_q_out.tdata, 16'hBBBB);
        tick();

        // ---- 3: backpressure ----
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 16'(16'h0100 + k), 1, 16'(16'h0200 + k), 0, 0);
            at_neg();
            if (k >= 4) begin
                chk("t3 I_in.tready full", if_i_in.tready, 1'b0);
                chk("t3 Q_in.tready full", if_q_in.tready, 1'b0);
                chk("t3 head I held", if_i_out.tdata, 16'h0100);
                chk("t3 head Q held", if_q_out.tdata, 16'h0200);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, 0, '0, 1, 1);
            at_neg();
            chk("t3 drain valid", if_i_out.tvalid, 1'b1);
            chk("t3 drain I", if_i_out.tdata, 16'(16'h0100 + k));
            chk("t3 drain Q", if_q_out.tdata, 16'(16'h0200 + k));
            tick();
        end
        at_neg();
        chk("t3 drained", if_i_out.tvalid, 1'b0);
        tick();

        // ---- 4: deadlock flag ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 16'(16'h0300 + k), 0, '0, 1, 1);
            tick();
        end
        drive(0, '0, 0, '0, 1, 1);
        at_neg();
        chk("t4 I_in.tready", if_i_in.tready, 1'b0);
        chk("t4 skew", skew, 4);
        chk("t4 skew_err", skew_err, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, 1, 16'(16'h0400 + k), 1, 1);
            tick();
        end
        drive(0, '0, 0, '0, 1, 1);
        repeat (6) tick();
        at_neg();
        chk("t4 skew_err sticky", skew_err, 1'b1);
        chk("t4 skew settled", skew, 0);
        tick();

        // ---- 5: full rate ----
        do_reset();
        p0 = d_pairs;
        for (int k = 0; k < 1000; k++) begin
            drive(1, 16'($urandom), 1, 16'($urandom), 1, 1);
            tick();
        end
        drive(0, '0, 0, '0, 1, 1);
        chk("t5 pairs per clk", d_pairs - p0, 999);
        tick();
        tick();

        // ---- 6: random valid/ready on all ports ----
        do_reset();
        p0 = m_pops;
        begin
            int dp0;
            dp0 = d_pairs;
            for (int k = 0; k < 10000; k++) begin
                drive($urandom_range(0, 99) < 60, 16'($urandom),
                      $urandom_range(0, 99) < 60, 16'($urandom),
                      $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
                tick();
            end
            drive(0, '0, 0, '0, 1, 1);
            repeat (8) tick();
            chk("t6 pair count", d_pairs - dp0, m_pops - p0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
